// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath blocks: FSM state encoding,
// default lane geometry and a generic sign-extension helper.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int MAC_A_W = 8;
  localparam int MAC_B_W = 8;
  localparam int MAC_H_W = MAC_B_W / 2;

  function automatic int half_w(input int b_w);
    return b_w / 2;
  endfunction

  // Sign-extend the low w bits of v to 64 bits; callers cast down to their width.
  function automatic logic signed [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] sh;
    sh = v << (64 - w);
    return $signed(sh) >>> (64 - w);
  endfunction

endpackage

// File: rtl/mac_pp_lane.sv
// One half-width shift-add partial-product accumulator. Consumes bit cnt of
// its B half per enabled cycle; the MSB step can carry negative weight.
module mac_pp_lane #(
  parameter int A_W   = 8,
  parameter int H_W   = 4,
  parameter int CNT_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   neg_msb,
  input  logic signed [A_W:0]    a,
  input  logic [H_W-1:0]         bits,
  input  logic [CNT_W-1:0]       cnt,
  output logic signed [A_W+H_W:0] acc
);

  localparam int ACC_W = A_W + H_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H_W - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] a_w;
  logic signed [ACC_W-1:0] term;
  logic                    bit_sel;
  logic                    sub;

  always_comb begin
    a_w     = {{H_W{a[A_W]}}, a};
    term    = a_w <<< cnt;
    bit_sel = bits[cnt];
    sub     = neg_msb && (cnt == CNT_LAST);
    acc_d   = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en && bit_sel) begin
      acc_d = sub ? (acc_q - term) : (acc_q + term);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mac_mul_seq.sv
// Multi-cycle signed multiplier: full A x B or two independent A x B-half
// products, with B consumed one bit per lane per cycle behind valid/ready.
module mac_mul_seq
  import mac_pkg::*;
#(
  parameter int A_W = 8,
  parameter int B_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_W-1:0]             a,
  input  logic [B_W-1:0]             b,
  input  logic                       split,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_W+B_W-1:0]         prod,
  output logic [A_W+half_w(B_W)-1:0] prod_lo,
  output logic [A_W+half_w(B_W)-1:0] prod_hi
);

  localparam int H_W   = half_w(B_W);
  localparam int P_W   = A_W + B_W;
  localparam int L_W   = A_W + H_W;
  localparam int ACC_W = L_W + 1;
  localparam int CNT_W = $clog2(H_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H_W - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [A_W:0]     a_q, a_d;
  logic [B_W-1:0]          b_q, b_d;
  logic                    split_q, split_d;
  logic signed [P_W-1:0]   prod_q, prod_d;
  logic signed [ACC_W-1:0] acc0, acc1;
  logic                    accept;
  logic                    lane_en;

  assign accept  = in_valid && in_ready;
  assign lane_en = (state_q == RUN);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = split_q ? DONE : FINISH;
      FINISH:  state_d = DONE;
      DONE:    if (out_ready) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; the inactive mode's products read as zero
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    prod      = '0;
    prod_lo   = '0;
    prod_hi   = '0;
    if (state_q == DONE) begin
      if (split_q) begin
        prod_lo = acc0[L_W-1:0];
        prod_hi = acc1[L_W-1:0];
      end else begin
        prod = prod_q;
      end
    end
  end

  // Operand capture, bit counter and final combine; lane0 holds the unsigned
  // low half in full mode, so only lane1 carries the sign weight.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    split_d = split_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    if (accept) begin
      a_d     = (A_W+1)'(sext(64'(a), A_W));
      b_d     = b;
      split_d = split;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_q == FINISH) begin
      prod_d = P_W'(((P_W+1)'(acc1) <<< H_W) + (P_W+1)'(acc0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      split_q <= 1'b0;
      prod_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      split_q <= split_d;
      prod_q  <= prod_d;
    end
  end

  mac_pp_lane #(
    .A_W   (A_W),
    .H_W   (H_W),
    .CNT_W (CNT_W)
  ) u_lane0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (lane_en),
    .neg_msb (split_q),
    .a       (a_q),
    .bits    (b_q[H_W-1:0]),
    .cnt     (cnt_q),
    .acc     (acc0)
  );

  mac_pp_lane #(
    .A_W   (A_W),
    .H_W   (H_W),
    .CNT_W (CNT_W)
  ) u_lane1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (lane_en),
    .neg_msb (1'b1),
    .a       (a_q),
    .bits    (b_q[B_W-1:H_W]),
    .cnt     (cnt_q),
    .acc     (acc1)
  );

endmodule

// File: tb/tb_mac_mul_seq.sv
// Bench for mac_mul_seq: directed vector table, backpressure and reset
// sequences, then randomized traffic on an 8x8 and a 12x6 instance.
module tb_mac_mul_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv1, ir1, s1, ov1, or1;
  logic [7:0]  a1, b1;
  logic [15:0] p1;
  logic [11:0] lo1, hi1;

  logic        iv2, ir2, s2, ov2, or2;
  logic [11:0] a2;
  logic [5:0]  b2;
  logic [17:0] p2;
  logic [14:0] lo2, hi2;

  mac_mul_seq #(.A_W(8), .B_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .split(s1), .out_valid(ov1), .out_ready(or1), .prod(p1), .prod_lo(lo1), .prod_hi(hi1)
  );

  mac_mul_seq #(.A_W(12), .B_W(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .split(s2), .out_valid(ov2), .out_ready(or2), .prod(p2), .prod_lo(lo2), .prod_hi(hi2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
    logic [11:0] lo;
    logic [11:0] hi;
    int          lat;
  } vec_t;

  typedef struct { logic [15:0] p; logic [11:0] lo; logic [11:0] hi; } exp1_t;
  typedef struct { logic [17:0] p; logic [14:0] lo; logic [14:0] hi; } exp2_t;

  // Called #1 after a rising edge with out_ready low; returns once out_valid
  // is seen (or the bound expires), lat = cycles from the accept edge.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts, output int lat);
    int n;
    a1 = ta; b1 = tb; s1 = ts; iv1 = 1'b1;
    n = 0;
    while (!ir1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  vec_t  vecs[10];
  exp1_t q1[$];
  exp2_t q2[$];

  initial begin
    int lat;
    int iss1, iss2, got1, got2;
    logic acc1_f, acc2_f;
    int ai, bi, li, hi_i;
    exp1_t e1;
    exp2_t e2;

    vecs[0] = '{8'hFD, 8'h07, 1'b0, 16'hFFEB, 12'h000, 12'h000, 5};
    vecs[1] = '{8'h05, 8'h3D, 1'b1, 16'h0000, 12'hFF1, 12'h00F, 4};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 16'h4000, 12'h000, 12'h000, 5};
    vecs[3] = '{8'h80, 8'h88, 1'b1, 16'h0000, 12'h400, 12'h400, 4};
    vecs[4] = '{8'h00, 8'h5A, 1'b0, 16'h0000, 12'h000, 12'h000, 5};
    vecs[5] = '{8'h37, 8'h00, 1'b1, 16'h0000, 12'h000, 12'h000, 4};
    vecs[6] = '{8'h7F, 8'h7F, 1'b0, 16'h3F01, 12'h000, 12'h000, 5};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 16'hC080, 12'h000, 12'h000, 5};
    vecs[8] = '{8'h7F, 8'h7F, 1'b1, 16'h0000, 12'hF81, 12'h379, 4};
    vecs[9] = '{8'hFF, 8'hFF, 1'b0, 16'h0001, 12'h000, 12'h000, 5};

    rst_n = 1'b0;
    iv1 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0; or1 = 1'b0;
    iv2 = 1'b0; a2 = '0; b2 = '0; s2 = 1'b0; or2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov1), 32'd0);
    chk("rst_in_ready", 32'(ir1), 32'd1);
    chk("rst_prod", 32'(p1), 32'd0);
    chk("rst_prod_lo", 32'(lo1), 32'd0);
    chk("rst_prod_hi", 32'(hi1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
      chk($sformatf("v%0d_prod", i), 32'(p1), 32'(vecs[i].p));
      chk($sformatf("v%0d_lo", i), 32'(lo1), 32'(vecs[i].lo));
      chk($sformatf("v%0d_hi", i), 32'(hi1), 32'(vecs[i].hi));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      release_out();
      chk($sformatf("v%0d_valid_drop", i), 32'(ov1), 32'd0);
    end

    // Backpressure, then a back-to-back accept in the release cycle
    run_op(8'h06, 8'hFB, 1'b0, lat);
    chk("bp_first_prod", 32'(p1), 32'h0000FFE2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", i), 32'(ov1), 32'd1);
      chk($sformatf("bp_hold%0d_prod", i), 32'(p1), 32'h0000FFE2);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(ir1), 32'd0);
    end
    a1 = 8'hF9; b1 = 8'h3A; s1 = 1'b1; iv1 = 1'b1; or1 = 1'b1;
    #1;
    chk("bp_in_ready_on_release", 32'(ir1), 32'd1);
    @(posedge clk); #1;
    iv1 = 1'b0; or1 = 1'b0;
    chk("bp_valid_after_release", 32'(ov1), 32'd0);
    chk("bp_busy_after_accept", 32'(ir1), 32'd0);
    lat = 0;
    while (!ov1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_second_latency", 32'(lat), 32'd4);
    chk("bp_second_lo", 32'(lo1), 32'h02A);
    chk("bp_second_hi", 32'(hi1), 32'hFEB);
    chk("bp_second_prod", 32'(p1), 32'd0);
    release_out();

    // Reset during the second RUN cycle
    a1 = 8'h64; b1 = 8'h64; s1 = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(ov1), 32'd0);
    chk("mid_rst_prod", 32'(p1), 32'd0);
    chk("mid_rst_lo", 32'(lo1), 32'd0);
    chk("mid_rst_hi", 32'(hi1), 32'd0);
    chk("mid_rst_in_ready", 32'(ir1), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h09, 8'hF7, 1'b0, lat);
    chk("post_rst_prod", 32'(p1), 32'h0000FFAF);
    chk("post_rst_latency", 32'(lat), 32'd5);
    release_out();

    // Random traffic on both instances against $signed reference products
    iss1 = 0; iss2 = 0; got1 = 0; got2 = 0;
    acc1_f = 1'b0; acc2_f = 1'b0;
    for (int cyc = 0; cyc < 40000 && (got1 < 1000 || got2 < 1000); cyc++) begin
      @(posedge clk); #1;
      if (acc1_f) iv1 = 1'b0;
      if (acc2_f) iv2 = 1'b0;
      if (!iv1 && iss1 < 1000 && $urandom_range(0, 2) != 0) begin
        a1 = 8'($urandom); b1 = 8'($urandom); s1 = 1'($urandom); iv1 = 1'b1;
      end
      if (!iv2 && iss2 < 1000 && $urandom_range(0, 2) != 0) begin
        a2 = 12'($urandom); b2 = 6'($urandom); s2 = 1'($urandom); iv2 = 1'b1;
      end
      or1 = ($urandom_range(0, 3) != 0);
      or2 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc1_f = iv1 && ir1;
      acc2_f = iv2 && ir2;
      if (ov1 && or1) begin
        if (q1.size() == 0) begin
          chk("rand1_unexpected_result", 32'(ov1), 32'd0);
        end else begin
          e1 = q1.pop_front();
          chk($sformatf("rand1_op%0d", got1), {4'd0, p1, lo1}, {4'd0, e1.p, e1.lo});
          chk($sformatf("rand1_op%0d_hi", got1), 32'(hi1), 32'(e1.hi));
        end
        got1++;
      end
      if (ov2 && or2) begin
        if (q2.size() == 0) begin
          chk("rand2_unexpected_result", 32'(ov2), 32'd0);
        end else begin
          e2 = q2.pop_front();
          chk($sformatf("rand2_op%0d_prod", got2), 32'(p2), 32'(e2.p));
          chk($sformatf("rand2_op%0d_lohi", got2), {2'd0, lo2, hi2}, {2'd0, e2.lo, e2.hi});
        end
        got2++;
      end
      if (acc1_f) begin
        ai = int'($signed(a1));
        bi = int'($signed(b1));
        li = int'($signed(b1[3:0]));
        hi_i = int'($signed(b1[7:4]));
        e1.p  = s1 ? 16'd0 : 16'(ai * bi);
        e1.lo = s1 ? 12'(ai * li) : 12'd0;
        e1.hi = s1 ? 12'(ai * hi_i) : 12'd0;
        q1.push_back(e1);
        iss1++;
      end
      if (acc2_f) begin
        ai = int'($signed(a2));
        bi = int'($signed(b2));
        li = int'($signed(b2[2:0]));
        hi_i = int'($signed(b2[5:3]));
        e2.p  = s2 ? 18'd0 : 18'(ai * bi);
        e2.lo = s2 ? 15'(ai * li) : 15'd0;
        e2.hi = s2 ? 15'(ai * hi_i) : 15'd0;
        q2.push_back(e2);
        iss2++;
      end
    end
    chk("rand1_results_count", 32'(got1), 32'd1000);
    chk("rand2_results_count", 32'(got2), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
